four_bit_serial_subtractor: RTL and testbench



---
 rtl/four_bit_serial_subtractor_pkg.sv | 13 +
 rtl/four_bit_serial_subtractor_cell.sv | 13 +
 rtl/four_bit_serial_subtractor.sv | 118 +++++++++++
 tb/tb_four_bit_serial_subtractor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/four_bit_serial_subtractor_pkg.sv
// Shared types and default sizing for the bit-serial subtractor.
package four_bit_serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 3;

endpackage

// File: rtl/four_bit_serial_subtractor_cell.sv
// One-bit full subtractor: diff = a - b - bin, bout is the borrow out.
module full_subtractor_dataflow_module (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/four_bit_serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Operands are captured on start; results are held from done until the next completion.
module four_bit_serial_subtractor
  import four_bit_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy,
  output logic             done
);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sh_reg, b_sh_reg, res_reg, diff_reg;
  logic [WIDTH-1:0] a_shr, b_shr, res_shr;
  logic [CNT_W-1:0] cnt_reg;
  logic             brw_reg, bout_reg, ovf_reg, a_msb_reg, b_msb_reg;
  logic             bit_diff, bit_bout;
  logic             accept, last_bit;

  assign accept   = start && (state_reg == IDLE || state_reg == DONE);
  assign last_bit = (state_reg == SHIFT) && (cnt_reg == CNT_W'(WIDTH - 1));

  full_subtractor_dataflow_module u_cell (
    .a    (a_sh_reg[0]),
    .b    (b_sh_reg[0]),
    .bin  (brw_reg),
    .diff (bit_diff),
    .bout (bit_bout)
  );

  // Operands shift right toward the cell; result bits enter from the MSB side.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign a_shr[gi]   = a_sh_reg[gi+1];
      assign b_shr[gi]   = b_sh_reg[gi+1];
      assign res_shr[gi] = res_reg[gi+1];
    end
  endgenerate

  assign a_shr[WIDTH-1]   = 1'b0;
  assign b_shr[WIDTH-1]   = 1'b0;
  assign res_shr[WIDTH-1] = bit_diff;

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = DONE;
      DONE:    state_next = start ? SHIFT : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_reg)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_sh_reg  <= '0;
      b_sh_reg  <= '0;
      res_reg   <= '0;
      brw_reg   <= 1'b0;
      cnt_reg   <= '0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else if (accept) begin
      a_sh_reg  <= a;
      b_sh_reg  <= b;
      brw_reg   <= bin;
      cnt_reg   <= '0;
      a_msb_reg <= a[WIDTH-1];
      b_msb_reg <= b[WIDTH-1];
    end else if (state_reg == SHIFT) begin
      a_sh_reg <= a_shr;
      b_sh_reg <= b_shr;
      res_reg  <= res_shr;
      brw_reg  <= bit_bout;
      cnt_reg  <= cnt_reg + CNT_W'(1);
      // Published outputs move only here, so they never show partial results.
      if (last_bit) begin
        diff_reg <= res_shr;
        bout_reg <= bit_bout;
        ovf_reg  <= (a_msb_reg != b_msb_reg) && (bit_diff != a_msb_reg);
      end
    end
  end

  assign diff = diff_reg;
  assign bout = bout_reg;
  assign ovf  = ovf_reg;

endmodule

// File: tb/tb_four_bit_serial_subtractor.sv
// Directed bench for the bit-serial subtractor; one line per transaction.
module tb_four_bit_serial_subtractor;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic [W-1:0] diff;
  logic         bout, ovf, busy, done;

  int errors = 0;
  int checks = 0;

  four_bit_serial_subtractor #(.WIDTH(W), .CNT_W(3)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .bin     (bin),
    .diff    (diff),
    .bout    (bout),
    .ovf     (ovf),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Issues one start pulse, then waits (bounded) for done; reports latency and busy cycles.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                        output int lat, output int busy_cyc);
    @(negedge clk);
    a = av; b = bv; bin = bi; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = 1;
    busy_cyc = 0;
    while (done !== 1'b1 && lat <= 20) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b1; a = 4'hF; b = 4'h1; bin = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({diff, bout, ovf, busy, done} !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got diff=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
               diff, bout, ovf, busy, done);
    end
    start = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", busy, done);
    end
    $display("reset: diff=%h bout=%b ovf=%b busy=%b done=%b", diff, bout, ovf, busy, done);
  endtask

  task automatic test_basic(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bi,
                            input logic [W-1:0] ed, input logic eb, input logic eo);
    int lat, bc;
    run_op(av, bv, bi, lat, bc);
    $display("op %h - %h - %b: diff=%h bout=%b ovf=%b lat=%0d busy=%0d",
             av, bv, bi, diff, bout, ovf, lat, bc);
    checks++;
    if (lat != W + 1) begin
      errors++;
      $display("FAIL basic_latency: got %0d, want %0d", lat, W + 1);
    end
    checks++;
    if (bc != W) begin
      errors++;
      $display("FAIL basic_busy_cycles: got %0d, want %0d", bc, W);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_busy_with_done: got busy=%b, want 0", busy);
    end
    checks++;
    if (diff !== ed || bout !== eb || ovf !== eo) begin
      errors++;
      $display("FAIL basic_result: got diff=%h bout=%b ovf=%b, want diff=%h bout=%b ovf=%b",
               diff, bout, ovf, ed, eb, eo);
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0;
    @(negedge clk);
    a = 4'd5; b = 4'd2; bin = 1'b0; start = 1'b1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
      if (k == 5 || k == 10) begin
        $display("b2b k=%0d: done=%b diff=%h bout=%b ovf=%b", k, done, diff, bout, ovf);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done_k%0d: got done=%b busy=%b, want 1 0", k, done, busy);
        end
        checks++;
        if (k == 5 && (diff !== 4'd3 || bout !== 1'b0 || ovf !== 1'b0)) begin
          errors++;
          $display("FAIL b2b_first: got diff=%h bout=%b ovf=%b, want 3 0 0", diff, bout, ovf);
        end
        if (k == 10 && (diff !== 4'd7 || bout !== 1'b0 || ovf !== 1'b1)) begin
          errors++;
          $display("FAIL b2b_second: got diff=%h bout=%b ovf=%b, want 7 0 1", diff, bout, ovf);
        end
      end else begin
        checks++;
        if (done !== 1'b0 || busy !== (k != 11)) begin
          errors++;
          $display("FAIL b2b_flags_k%0d: got done=%b busy=%b", k, done, busy);
        end
        if (k >= 6 && k <= 9) begin
          checks++;
          if (diff !== 4'd3) begin
            errors++;
            $display("FAIL b2b_hold_k%0d: got diff=%h, want 3", k, diff);
          end
        end
      end
      if (k == 5) begin
        a = 4'd12; b = 4'd4; bin = 1'b1;
      end else begin
        a = 4'($urandom_range(15)); b = 4'($urandom_range(15)); bin = 1'($urandom_range(1));
      end
      if (k == 10) start = 1'b0;
    end
    checks++;
    if (dones != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, want 2", dones);
    end
  endtask

  task automatic test_mid_reset();
    int lat, bc, dones = 0;
    @(negedge clk);
    a = 4'd9; b = 4'd3; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    $display("mid_reset: diff=%h bout=%b ovf=%b busy=%b done=%b", diff, bout, ovf, busy, done);
    checks++;
    if ({diff, bout, ovf, busy, done} !== 8'h00) begin
      errors++;
      $display("FAIL midreset_outputs: got diff=%h bout=%b ovf=%b busy=%b done=%b, want all 0",
               diff, bout, ovf, busy, done);
    end
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midreset_no_done: got %0d active cycles, want 0", dones);
    end
    run_op(4'd7, 4'd7, 1'b0, lat, bc);
    $display("op 7 - 7 - 0 after reset: diff=%h bout=%b lat=%0d", diff, bout, lat);
    checks++;
    if (lat != W + 1 || diff !== 4'd0 || bout !== 1'b0) begin
      errors++;
      $display("FAIL midreset_followup: got diff=%h bout=%b lat=%0d, want 0 0 %0d",
               diff, bout, lat, W + 1);
    end
  endtask

  task automatic test_sweep();
    int off, lat, bc, r, sr;
    logic [8:0] v;
    logic [W-1:0] ed;
    logic eb, eo;
    off = int'($urandom_range(511));
    for (int i = 0; i < 512; i++) begin
      v = 9'((i * 5 + off) % 512);
      r  = int'(v[3:0]) - int'(v[7:4]) - int'(v[8]);
      sr = int'($signed(v[3:0])) - int'($signed(v[7:4])) - int'(v[8]);
      ed = 4'(r);
      eb = (r < 0);
      eo = (sr > 7) || (sr < -8);
      run_op(v[3:0], v[7:4], v[8], lat, bc);
      $display("sweep %h - %h - %b: diff=%h bout=%b ovf=%b lat=%0d",
               v[3:0], v[7:4], v[8], diff, bout, ovf, lat);
      checks++;
      if (lat != W + 1) begin
        errors++;
        $display("FAIL sweep_latency: got %0d, want %0d", lat, W + 1);
      end
      checks++;
      if (diff !== ed || bout !== eb || ovf !== eo) begin
        errors++;
        $display("FAIL sweep_result %h-%h-%b: got %h %b %b, want %h %b %b",
                 v[3:0], v[7:4], v[8], diff, bout, ovf, ed, eb, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic(4'd9, 4'd3, 1'b0, 4'd6, 1'b0, 1'b1);
    test_basic(4'd3, 4'd9, 1'b0, 4'hA, 1'b1, 1'b1);
    test_basic(4'd8, 4'd1, 1'b0, 4'd7, 1'b0, 1'b1);
    test_basic(4'd0, 4'd0, 1'b1, 4'hF, 1'b1, 1'b0);
    test_mid_reset();
    test_back_to_back();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
